// File: rtl/alu_pipe.sv
// Two-stage registered 6502 ALU: stage 1 captures operands and forms sums/logic results,
// stage 2 selects the result, applies decimal adjust (ALU_PIPE_BCD_EN) and registers flags.
module alu_pipe (
    input  logic       clk,
    input  logic       resetn,
    input  logic       alu_start,
    input  logic [2:0] alu_ctrl,
    input  logic [7:0] alu_AI,
    input  logic [7:0] alu_BI,
    input  logic       alu_carry,
    input  logic       alu_BCD,
    output logic [7:0] alu_Y,
    output logic [7:0] alu_flags,
    output logic       alu_valid
);

    typedef enum logic [2:0] {
        OP_SUM = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_AND = 3'b011,
        OP_SR  = 3'b100
    } op_e;

    // Signed-overflow rule: operands of equal sign producing a result of the other sign.
    function automatic logic ovf_flag(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] y);
        return ~(a[7] ^ b[7]) & (a[7] ^ y[7]);
    endfunction

`ifdef ALU_PIPE_BCD_EN
    // Returns {Y[7:0], C, V}; V is taken before the high-nibble adjust.
    function automatic logic [9:0] bcd_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [4:0] lo_sum);
        logic [4:0] lo;
        logic [4:0] hi;
        logic       hc;
        logic       c;
        logic       v;
        lo = lo_sum;
        hc = 1'b0;
        if (lo > 5'd9) begin
            lo = lo + 5'd6;
            hc = 1'b1;
        end
        hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, hc};
        v  = ovf_flag(a, b, {hi[3:0], lo[3:0]});
        c  = 1'b0;
        if (hi > 5'd9) begin
            hi = hi + 5'd6;
            c  = 1'b1;
        end
        return {hi[3:0], lo[3:0], c, v};
    endfunction
`endif

    logic [8:0] sum_p0_d;
    logic [7:0] and_p0_d;
    logic [7:0] or_p0_d;
    logic [7:0] xor_p0_d;

    logic       vld_p1_q;
    logic [2:0] ctrl_p1_q;
    logic [7:0] ai_p1_q;
    logic [7:0] bi_p1_q;
    logic       carry_p1_q;
    logic [8:0] sum_p1_q;
    logic [7:0] and_p1_q;
    logic [7:0] or_p1_q;
    logic [7:0] xor_p1_q;

    logic [7:0] y_p2_d;
    logic [7:0] flags_p2_d;
    logic       c_p2_d;
    logic       v_p2_d;

    logic       vld_p2_q;
    logic [7:0] y_p2_q;
    logic [7:0] flags_p2_q;

    always_comb begin
        sum_p0_d = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry};
        and_p0_d = alu_AI & alu_BI;
        or_p0_d  = alu_AI | alu_BI;
        xor_p0_d = alu_AI ^ alu_BI;
    end

`ifdef ALU_PIPE_BCD_EN
    logic [4:0] lo_p0_d;
    logic [4:0] lo_p1_q;
    logic       bcd_p1_q;

    always_comb begin
        lo_p0_d = {1'b0, alu_AI[3:0]} + {1'b0, alu_BI[3:0]} + {4'd0, alu_carry};
    end

    always_ff @(posedge clk) begin
        if (alu_start) begin
            lo_p1_q  <= lo_p0_d;
            bcd_p1_q <= alu_BCD;
        end
    end
`else
    logic bcd_unused;
    assign bcd_unused = alu_BCD;
`endif

    // Stage 1: operand capture; data only loads on an accepted start
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= alu_start;
        end
    end

    always_ff @(posedge clk) begin
        if (alu_start) begin
            ctrl_p1_q  <= alu_ctrl;
            ai_p1_q    <= alu_AI;
            bi_p1_q    <= alu_BI;
            carry_p1_q <= alu_carry;
            sum_p1_q   <= sum_p0_d;
            and_p1_q   <= and_p0_d;
            or_p1_q    <= or_p0_d;
            xor_p1_q   <= xor_p0_d;
        end
    end

    always_comb begin
        y_p2_d = 8'h00;
        c_p2_d = 1'b0;
        v_p2_d = 1'b0;
        case (ctrl_p1_q)
            OP_SUM: begin
                y_p2_d = sum_p1_q[7:0];
                c_p2_d = sum_p1_q[8];
                v_p2_d = ovf_flag(ai_p1_q, bi_p1_q, sum_p1_q[7:0]);
`ifdef ALU_PIPE_BCD_EN
                if (bcd_p1_q) begin
                    {y_p2_d, c_p2_d, v_p2_d} = bcd_add(ai_p1_q, bi_p1_q, lo_p1_q);
                end
`endif
            end
            OP_OR:  y_p2_d = or_p1_q;
            OP_XOR: y_p2_d = xor_p1_q;
            OP_AND: y_p2_d = and_p1_q;
            OP_SR: begin
                y_p2_d = {carry_p1_q, ai_p1_q[7:1]};
                c_p2_d = ai_p1_q[0];
            end
            default: y_p2_d = 8'h00;
        endcase
        flags_p2_d = {y_p2_d[7], v_p2_d, 4'b0000, (y_p2_d == 8'h00), c_p2_d};
    end

    // Stage 2: result/flag registers, held between valid pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p2_q   <= 1'b0;
            y_p2_q     <= 8'h00;
            flags_p2_q <= 8'h00;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                y_p2_q     <= y_p2_d;
                flags_p2_q <= flags_p2_d;
            end
        end
    end

    assign alu_Y     = y_p2_q;
    assign alu_flags = flags_p2_q;
    assign alu_valid = vld_p2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: integer-arithmetic reference model, timestamped expectation
// queue, one per-cycle compare process. Honours ALU_PIPE_BCD_EN like the design.
module tb_alu_pipe;

`ifdef ALU_PIPE_BCD_EN
    localparam bit BCD_ON = 1'b1;
`else
    localparam bit BCD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       alu_start;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry;
    logic       alu_BCD;
    logic [7:0] alu_Y;
    logic [7:0] alu_flags;
    logic       alu_valid;

    alu_pipe dut (
        .clk       (clk),
        .resetn    (resetn),
        .alu_start (alu_start),
        .alu_ctrl  (alu_ctrl),
        .alu_AI    (alu_AI),
        .alu_BI    (alu_BI),
        .alu_carry (alu_carry),
        .alu_BCD   (alu_BCD),
        .alu_Y     (alu_Y),
        .alu_flags (alu_flags),
        .alu_valid (alu_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] y;
        logic [7:0] f;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Returns {Y, flags}, computed with plain integer arithmetic.
    function automatic logic [15:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c,
                                          input logic bcd);
        int ai, bi, ci, y, cf, v, lo, hi, hc, yv;
        ai = int'(a);
        bi = int'(b);
        ci = c ? 1 : 0;
        y  = 0;
        cf = 0;
        v  = 0;
        case (op)
            3'd0: begin
                if (bcd && BCD_ON) begin
                    lo = (ai % 16) + (bi % 16) + ci;
                    hc = (lo > 9) ? 1 : 0;
                    if (hc == 1) lo = lo + 6;
                    hi = (ai / 16) + (bi / 16) + hc;
                    yv = (hi % 16) * 16 + (lo % 16);
                    v  = (((ai >= 128) == (bi >= 128)) && ((ai >= 128) != (yv >= 128))) ? 1 : 0;
                    cf = (hi > 9) ? 1 : 0;
                    if (cf == 1) hi = hi + 6;
                    y  = (hi % 16) * 16 + (lo % 16);
                end else begin
                    y  = (ai + bi + ci) % 256;
                    cf = (ai + bi + ci) / 256;
                    v  = (((ai >= 128) == (bi >= 128)) && ((ai >= 128) != (y >= 128))) ? 1 : 0;
                end
            end
            3'd1: y = int'(a | b);
            3'd2: y = int'(a ^ b);
            3'd3: y = int'(a & b);
            3'd4: begin
                y  = ci * 128 + ai / 2;
                cf = ai % 2;
            end
            default: y = 0;
        endcase
        return {8'(y), 8'((y >= 128 ? 128 : 0) + v * 64 + (y == 0 ? 2 : 0) + cf)};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pin(input string name, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic bcd,
                       input logic [7:0] ey, input logic [7:0] ef);
        logic [15:0] r;
        r = model(op, a, b, c, bcd);
        chk({name, "_Y"}, r[15:8], ey);
        chk({name, "_flags"}, r[7:0], ef);
    endtask

    // Reference model plus per-cycle comparison of every output
    initial begin : monitor
        exp_t        q[$];
        exp_t        e;
        logic [15:0] r;
        logic [7:0]  last_y;
        logic [7:0]  last_f;
        bit          rst_seen;
        int          cyc;
        cyc    = 0;
        last_y = 8'h00;
        last_f = 8'h00;

        pin("pin_bin_ovf", 3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 8'hC0);
        pin("pin_dec_add", 3'd0, 8'h19, 8'h28, 1'b0, 1'b1, BCD_ON ? 8'h47 : 8'h41, 8'h00);
        pin("pin_dec_wrap", 3'd0, 8'h99, 8'h01, 1'b0, 1'b1, BCD_ON ? 8'h00 : 8'h9A,
            BCD_ON ? 8'h03 : 8'h80);
        pin("pin_sr", 3'd4, 8'h81, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h81);
        pin("pin_undef", 3'd6, 8'h55, 8'h66, 1'b1, 1'b0, 8'h00, 8'h02);
        pin("pin_and", 3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 8'h00);
        pin("pin_or", 3'd1, 8'h0F, 8'h30, 1'b0, 1'b0, 8'h3F, 8'h00);
        pin("pin_xor", 3'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h02);
        pin("pin_sub", 3'd0, 8'h10, 8'hDF, 1'b1, 1'b0, 8'hF0, 8'h80);

        forever begin
            @(posedge clk);
            cyc++;
            rst_seen = !resetn;
            if (!resetn) begin
                q.delete();
            end else if (alu_start) begin
                r = model(alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD);
                e.due = cyc + 1;
                e.y   = r[15:8];
                e.f   = r[7:0];
                q.push_back(e);
            end
            @(negedge clk);
            if (rst_seen) begin
                last_y = 8'h00;
                last_f = 8'h00;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("valid_pulse", {7'd0, alu_valid}, 8'h01);
                chk("result_Y", alu_Y, e.y);
                chk("result_flags", alu_flags, e.f);
                last_y = e.y;
                last_f = e.f;
            end else begin
                chk("valid_idle", {7'd0, alu_valid}, 8'h00);
                chk("hold_Y", alu_Y, last_y);
                chk("hold_flags", alu_flags, last_f);
            end
            if (done) break;
        end
        chk("drained", 8'(q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic bcd);
        alu_ctrl  = op;
        alu_AI    = a;
        alu_BI    = b;
        alu_carry = c;
        alu_BCD   = bcd;
        alu_start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alu_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            alu_ctrl  = 3'($urandom_range(0, 7));
            alu_AI    = 8'($urandom);
            alu_BI    = 8'($urandom);
            alu_carry = 1'($urandom);
            alu_BCD   = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stimulus
        resetn    = 1'b0;
        alu_start = 1'b0;
        alu_ctrl  = 3'd0;
        alu_AI    = 8'h00;
        alu_BI    = 8'h00;
        alu_carry = 1'b0;
        alu_BCD   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        drive(3'd0, 8'h50, 8'h50, 1'b0, 1'b0); idle(3);
        drive(3'd0, 8'h19, 8'h28, 1'b0, 1'b1); idle(3);
        drive(3'd0, 8'h99, 8'h01, 1'b0, 1'b1); idle(2);
        drive(3'd4, 8'h81, 8'h5A, 1'b1, 1'b0);
        drive(3'd6, 8'h12, 8'h34, 1'b1, 1'b1); idle(3);

        drive(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0);
        drive(3'd1, 8'h0F, 8'h30, 1'b0, 1'b0);
        drive(3'd2, 8'hFF, 8'hFF, 1'b0, 1'b0); idle(3);

        drive(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        drive(3'd0, 8'h10, 8'hDF, 1'b1, 1'b0);
        drive(3'd4, 8'h01, 8'h00, 1'b0, 1'b0);
        drive(3'd0, 8'h45, 8'h54, 1'b1, 1'b1);
        drive(3'd5, 8'hAA, 8'h55, 1'b0, 1'b0);
        drive(3'd7, 8'h00, 8'h00, 1'b1, 1'b1); idle(3);

        drive(3'd0, 8'h12, 8'h34, 1'b0, 1'b0);
        resetn    = 1'b0;
        alu_start = 1'b1;
        alu_ctrl  = 3'd1;
        alu_AI    = 8'h80;
        alu_BI    = 8'h01;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(4);
        drive(3'd1, 8'h80, 8'h01, 1'b0, 1'b0); idle(3);

        for (int i = 0; i < 24; i++) begin
            drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom));
        end
        idle(4);
        done = 1'b1;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage registered arithmetic/logic unit for the 6502 core, sitting directly downstream of the processor's ALU control outputs (`alu_ctrl`, `alu_AI`, `alu_BI`, `alu_carry`, `alu_BCD`). It returns `alu_Y` and `alu_flags` to the processor, with flags bit-aligned to the processor status register. Decimal-mode addition is performed in a dedicated second stage so that no stage has a long carry-plus-adjust path. The unit is fully pipelined: one operation is accepted per cycle with fixed latency.

## Interface
- No parameters.
- `clk` — in — 1 — clock.
- `resetn` — in — 1 — reset, synchronous, active-low.
- `alu_start` — in — 1 — the operand/control set on this cycle is valid; accepted every cycle with no backpressure.
- `alu_ctrl` — in — 3 — operation select:
  - 000 SUM, 001 OR, 010 XOR, 011 AND, 100 SR.
  - 101–111 are undefined.
- `alu_AI` — in — 8 — operand A.
- `alu_BI` — in — 8 — operand B. The processor pre-inverts B for subtraction. B is ignored for SR.
- `alu_carry` — in — 1 — carry-in for SUM; bit shifted into bit 7 for SR.
- `alu_BCD` — in — 1 — decimal mode; affects SUM only.
- `alu_Y` — out — 8 — result.
- `alu_flags` — out — 8 — result flags:
  - bit 7 N, bit 6 V, bit 1 Z, bit 0 C.
  - All other bits are always 0.
- `alu_valid` — out — 1 — one-cycle pulse marking a new `alu_Y`/`alu_flags`.

## Operation
- **Stage 1** (registers at the edge where `alu_start`=1):
  - Captures `ctrl`, `AI`, `BI`, `carry`, `BCD` and a stage valid bit.
  - Computes the 9-bit binary sum `AI+BI+carry`.
  - Computes the 5-bit low-nibble sum `AI[3:0]+BI[3:0]+carry`.
  - Computes the logic results.
- **Stage 2** (registers the next edge) selects the result and flags.
- **SUM, binary:**
  - Y = sum[7:0]; C = sum[8].
  - V = (~(AI^BI) & (AI^Y))[7].
- **SUM, decimal** (`alu_BCD`=1, macro enabled):
  - Low nibble L (5-bit): if L>9, L=L+6 and half-carry hc=1; else hc=0.
  - High nibble H (5-bit) = AI[7:4]+BI[7:4]+hc.
  - V is computed as in binary mode, but on {H[3:0], L[3:0]} taken before the high-nibble adjust.
  - If H>9: H=H+6 and C=1; else C=0.
  - Y = {H[3:0], L[3:0]}.
  - Decimal correction is addition-only. Decimal subtraction is not supported.
- **OR / XOR / AND:** Y = AI op BI; V=0, C=0.
- **SR:** Y = {alu_carry, AI[7:1]}; C = AI[0]; V=0. The processor drives carry=0 for LSR.
- **Undefined ctrl:** Y=8'h00, flags=8'h02.
- **All operations:** N = Y[7], Z = (Y==8'h00), evaluated on the final Y.
- **Output hold:** `alu_Y` and `alu_flags` hold the last result while `alu_valid`=0.
- **Reset values:** `alu_Y`=8'h00, `alu_flags`=8'h00, `alu_valid`=0, both stage valid bits = 0.
- **Reset mid-operation:** in-flight operations are discarded. No `alu_valid` pulse occurs after reset deasserts until a new `alu_start`.
- **Start during reset:** `alu_start` asserted while `resetn`=0 is ignored.

## Timing
- **Latency:** `alu_start` sampled high at edge N gives `alu_valid`=1 in the cycle following edge N+1.
- **Throughput:** `alu_start` may be held high every cycle. Results emerge in issue order, one per cycle, with `alu_valid` high continuously.
- **Operand stability:** operands need only be stable at the sampling edge. Later changes to the inputs do not affect an accepted operation.
- **Pipeline flow:** no stall or flush input; every accepted operation completes unless reset intervenes.
- **Registered outputs:** all outputs come straight from flops, with no combinational path from inputs to outputs.

## Configuration
- **Macro:** `ALU_PIPE_BCD_EN`.
- **Defined:**
  - Decimal adjust logic is compiled in.
  - SUM with `alu_BCD`=1 behaves as in Operation.
- **Undefined:**
  - The adjust logic is removed and `alu_BCD` is ignored.
  - SUM is always binary.
  - Latency and all other behaviour are unchanged.

## Test plan
- **Binary overflow:** SUM, AI=0x50, BI=0x50, carry=0, BCD=0 → two cycles later `alu_valid` pulses, Y=0xA0, flags=0xC0.
- **Decimal add:** SUM, AI=0x19, BI=0x28, carry=0, BCD=1 (macro on) → Y=0x47, flags=0x00. With the macro off → Y=0x41, flags=0x00.
- **Decimal wrap:** SUM, AI=0x99, BI=0x01, carry=0, BCD=1 → Y=0x00, flags=0x03.
- **Shift:** SR, AI=0x81, carry=1 → Y=0xC0, flags=0x81. Undefined ctrl=3'b110 → Y=0x00, flags=0x02.
- **Back-to-back:** `alu_start` high for 3 consecutive cycles issuing AND 0xF0&0x3C, OR 0x0F|0x30, XOR 0xFF^0xFF → `alu_valid` high 3 consecutive cycles with Y=0x30 (flags 0x00), 0x3F (flags 0x00), 0x00 (flags 0x02), in order.
- **Reset mid-flight:** issue SUM, then assert `resetn`=0 on the next edge for one cycle → no `alu_valid` pulse, Y=0x00, flags=0x00 after reset. A fresh start afterwards completes normally.
